// File: rtl/irq_ctrl.sv
// Vectored interrupt controller for the i8080 core.
// Latches request edges, signals iint and supplies RST n during INTA.
module irq_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int XLEN    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               inte,
    input  logic               sync,
    input  logic               dbin,
    input  logic [7:0]         data_in,
    output logic               int_o,
    output logic [XLEN-1:0]    data_out,
    output logic               data_oe,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int STATUS_INTA = 0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        DRIVE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [2:0]         winner;
    logic [2:0]         grant;
    logic               grant_valid;
    logic               any_elig;
    logic               inta;

    assign irq_edge = irq_req & ~irq_prev;
    assign eligible = pending & ~irq_mask;
    assign any_elig = |eligible;
    assign inta     = sync & data_in[STATUS_INTA];
    assign data_oe  = dbin & ((state == ACK) | (state == DRIVE));

    // Lowest set index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 3'(i);
        end
    end

    always_comb begin
        clr = '0;
        if (state == ACK && dbin && grant_valid) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (grant == 3'(i)) clr[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (inta)
                    state_nx = ACK;
                else if (any_elig && inte)
                    state_nx = REQ;
            end
            REQ: begin
                if (inta)
                    state_nx = ACK;
                else if (!(any_elig && inte))
                    state_nx = IDLE;
            end
            ACK: begin
                if (dbin) state_nx = DRIVE;
            end
            DRIVE: begin
                if (!dbin) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            irq_prev    <= '0;
            pending     <= '0;
            int_o       <= 1'b0;
            data_out    <= 8'h00;
            grant       <= '0;
            grant_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            irq_prev <= irq_req;
            // A fresh edge beats the grant clear on the same cycle.
            pending  <= (pending & ~clr) | irq_edge;
            int_o    <= (state_nx == REQ);
            if (state == IDLE && inta) begin
                grant_valid <= 1'b0;
                data_out    <= 8'hFF;
            end else if (state == REQ && inta) begin
                grant       <= winner;
                grant_valid <= any_elig;
                data_out    <= any_elig ? (8'hC7 | {2'b00, winner, 3'b000})
                                        : 8'hFF;
            end
        end
    end

endmodule
